mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, fixed-latency memory between the core's instruction-fetch port and its data (load/store) port. It sits between the core and unified instruction/data memory, replacing separate instruction and data memories. It grants one access per slot, tracks the single outstanding read, and returns read data to its owner. Requesters that are not granted are held off; the core converts the missing grant into its fetch or writeback stall.

---
 rtl/skylark_mem_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skylark_mem_pkg.sv
// Shared types and parameter limits for the unified instruction/data memory arbiter.
package skylark_mem_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

    function automatic bit memLatLegal(input int unsigned lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: bit 0 = instruction port, bit 1 = data port.
module rr_arb2
    import skylark_mem_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = (last == OWN_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Define MEM_ARB_DATA_PRIO_EN for fixed data-port priority instead of round-robin.
module mem_port_arbiter
    import skylark_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned cntW = $clog2(MEM_LAT + 1);

    if (!memLatLegal(MEM_LAT)) begin : gBadLat
        $error("mem_port_arbiter: MEM_LAT must be within 1..4");
    end

    arb_state_t        stateReg, stateNext;
    logic [cntW-1:0]   cntReg, cntNext;
    arb_owner_t        ownerReg, ownerNext;
    logic              iRvalidReg, dRvalidReg;
    logic [DATA_W-1:0] iRdataReg, dRdataReg;
    logic [1:0]        reqVec, arbGnt;
    logic              slotFree, readGrant, respNext;

    assign reqVec = {d_req, i_req};

`ifdef MEM_ARB_DATA_PRIO_EN
    assign arbGnt = d_req ? 2'b10 : reqVec;
`else
    arb_owner_t lastReg;

    rr_arb2 u_rrArb (
        .req  (reqVec),
        .last (lastReg),
        .gnt  (arbGnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastReg <= OWN_D;
        end else if (i_gnt) begin
            lastReg <= OWN_I;
        end else if (d_gnt) begin
            lastReg <= OWN_D;
        end
    end
`endif

    // The response cycle of a read doubles as the next issue slot.
    assign slotFree  = (stateReg == IDLE) || iRvalidReg || dRvalidReg;
    assign i_gnt     = slotFree & arbGnt[0];
    assign d_gnt     = slotFree & arbGnt[1];
    assign readGrant = i_gnt | (d_gnt & ~d_we);

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        ownerNext = ownerReg;
        if (readGrant) begin
            stateNext = WAIT;
            cntNext   = cntW'(MEM_LAT);
            ownerNext = i_gnt ? OWN_I : OWN_D;
        end else if (stateReg == WAIT) begin
            cntNext = cntReg - cntW'(1);
            if (cntReg == cntW'(1)) begin
                stateNext = IDLE;
            end
        end
    end

    // rvalid covers the cycle whose closing edge takes cnt down to zero.
    assign respNext = (stateNext == WAIT) && (cntNext == cntW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            ownerReg   <= OWN_I;
            iRvalidReg <= 1'b0;
            dRvalidReg <= 1'b0;
            iRdataReg  <= '0;
            dRdataReg  <= '0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            ownerReg   <= ownerNext;
            iRvalidReg <= respNext && (ownerNext == OWN_I);
            dRvalidReg <= respNext && (ownerNext == OWN_D);
            if (iRvalidReg) begin
                iRdataReg <= mem_rdata;
            end
            if (dRvalidReg) begin
                dRdataReg <= mem_rdata;
            end
        end
    end

    // Memory data is live in the rvalid cycle; the holding register keeps it afterwards.
    assign i_rvalid = iRvalidReg;
    assign d_rvalid = dRvalidReg;
    assign i_rdata  = iRvalidReg ? mem_rdata : iRdataReg;
    assign d_rdata  = dRvalidReg ? mem_rdata : dRdataReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1..3), directed stimulus, response scoreboard.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]       iReq, iGnt, iRvalid, dReq, dWe, dGnt, dRvalid, memEn, memWe;
    logic [NI-1:0][31:0] iAddr, iRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;

    typedef struct {
        int          inst;
        bit          own;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    rsp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : gDut
        logic [31:0] pipe [gi+1];

        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (gi + 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .i_req     (iReq[gi]),
            .i_addr    (iAddr[gi]),
            .i_gnt     (iGnt[gi]),
            .i_rvalid  (iRvalid[gi]),
            .i_rdata   (iRdata[gi]),
            .d_req     (dReq[gi]),
            .d_we      (dWe[gi]),
            .d_addr    (dAddr[gi]),
            .d_wdata   (dWdata[gi]),
            .d_gnt     (dGnt[gi]),
            .d_rvalid  (dRvalid[gi]),
            .d_rdata   (dRdata[gi]),
            .mem_en    (memEn[gi]),
            .mem_we    (memWe[gi]),
            .mem_addr  (memAddr[gi]),
            .mem_wdata (memWdata[gi]),
            .mem_rdata (memRdata[gi])
        );

        // Memory model: read data shows up gi+1 cycles after the strobe.
        always @(posedge clk) begin
            pipe[0] <= (memEn[gi] && !memWe[gi]) ? memFn(memAddr[gi]) : 32'hDEAD0BAD;
            for (int j = 1; j <= gi; j++) pipe[j] <= pipe[j-1];
        end
        assign memRdata[gi] = pipe[gi];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input bit own, input logic [31:0] data, input int at);
        rsp_t e;
        e.inst = inst; e.own = own; e.data = data; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic popCheck(input int inst, input bit own, input logic [31:0] data);
        rsp_t e;
        $display("rsp inst=%0d own=%s data=%h cyc=%0d", inst, own ? "D" : "I", data, cyc);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid actual=inst%0d/%0d required=none cyc=%0d", inst, own, cyc);
        end else begin
            e = sbq.pop_front();
            chk("rsp_route_time", {8'(inst), 8'(own), 32'(cyc)}, {8'(e.inst), 8'(e.own), 32'(e.cyc)});
            chk("rsp_data", data, e.data);
        end
    endtask

    // Response monitor: every rvalid on any instance must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (iRvalid[k]) popCheck(k, 1'b0, iRdata[k]);
                if (dRvalid[k]) popCheck(k, 1'b1, dRdata[k]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic doReset();
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int  c0;
        bit  expI;
        iReq = '0; dReq = '0; dWe = '0;
        iAddr = '0; dAddr = '0; dWdata = '0;

        // Reset values
        repeat (2) tick();
        mid();
        for (int k = 0; k < NI; k++) begin
            chk("rst_flags", 64'({iRvalid[k], dRvalid[k], iGnt[k], dGnt[k], memEn[k]}), 64'd0);
            chk("rst_rdata", {iRdata[k], dRdata[k]}, 64'd0);
        end
        tick();
        reset = 1'b1;

        // Single fetch, MEM_LAT = 1
        tick();
        iReq[0] = 1'b1; iAddr[0] = 32'h100;
        mid();
        c0 = cyc;
        chk("t1_i_gnt", 64'({iGnt[0], dGnt[0], memEn[0], memWe[0]}), 64'b1010);
        chk("t1_mem_addr", memAddr[0], 32'h100);
        push(0, 1'b0, 32'h00500093, c0 + 1);
        tick();
        iReq[0] = 1'b0;
        mid();
        chk("t1_no_gnt", 64'({iGnt[0], dGnt[0], memEn[0]}), 64'd0);
        tick();
        mid();
        chk("t1_rdata_hold", iRdata[0], 32'h00500093);

        // Tie between both ports, loads, MEM_LAT = 1
        doReset();
        tick();
        iReq[0] = 1'b1; iAddr[0] = 32'h200;
        dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h300;
        for (int k = 0; k < 8; k++) begin
            mid();
`ifdef MEM_ARB_DATA_PRIO_EN
            expI = 1'b0;
`else
            expI = (k % 2) == 0;
`endif
            chk("tie_i_gnt", 64'(iGnt[0]), 64'(expI));
            chk("tie_d_gnt", 64'(dGnt[0]), 64'(!expI));
            push(0, !expI, memFn(expI ? iAddr[0] : dAddr[0]), cyc + 1);
            tick();
            if (expI) iAddr[0] = iAddr[0] + 32'd4;
            else      dAddr[0] = dAddr[0] + 32'd4;
        end
        iReq[0] = 1'b0; dReq[0] = 1'b0;
        repeat (2) tick();

        // Back-to-back loads, MEM_LAT = 3
        dReq[2] = 1'b1; dWe[2] = 1'b0; dAddr[2] = 32'h10;
        mid();
        c0 = cyc;
        chk("lat3_gnt0", 64'(dGnt[2]), 64'd1);
        push(2, 1'b1, memFn(32'h10), c0 + 3);
        tick();
        dAddr[2] = 32'h14;
        for (int k = 1; k < 3; k++) begin
            mid();
            chk("lat3_hold_off", 64'({dGnt[2], memEn[2]}), 64'd0);
            tick();
        end
        mid();
        chk("lat3_gnt3", 64'({dGnt[2], memEn[2]}), 64'b11);
        chk("lat3_addr3", memAddr[2], 32'h14);
        push(2, 1'b1, memFn(32'h14), cyc + 3);
        tick();
        dReq[2] = 1'b0;
        repeat (4) tick();

        // Store while a fetch is outstanding, MEM_LAT = 2
        iReq[1] = 1'b1; iAddr[1] = 32'h40;
        mid();
        chk("st_i_gnt", 64'(iGnt[1]), 64'd1);
        push(1, 1'b0, memFn(32'h40), cyc + 2);
        tick();
        iReq[1] = 1'b0;
        dReq[1] = 1'b1; dWe[1] = 1'b1; dAddr[1] = 32'h80; dWdata[1] = 32'hDEADBEEF;
        mid();
        chk("st_withheld", 64'({dGnt[1], memEn[1]}), 64'd0);
        tick();
        mid();
        chk("st_gnt", 64'({dGnt[1], memWe[1], iRvalid[1]}), 64'b111);
        chk("st_wdata", {memAddr[1], memWdata[1]}, {32'h80, 32'hDEADBEEF});
        tick();
        dReq[1] = 1'b0; dWe[1] = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a read, MEM_LAT = 3
        iReq[2] = 1'b1; iAddr[2] = 32'h60;
        mid();
        chk("rm_i_gnt", 64'(iGnt[2]), 64'd1);
        tick();
        iReq[2] = 1'b0;
        tick();
        reset = 1'b0;
        mid();
        chk("rm_flags", 64'({iRvalid[2], dRvalid[2], iGnt[2], dGnt[2], memEn[2]}), 64'd0);
        chk("rm_rdata", {iRdata[2], dRdata[2]}, 64'd0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        dReq[2] = 1'b1; dWe[2] = 1'b0; dAddr[2] = 32'h70;
        mid();
        chk("rm_regrant", 64'(dGnt[2]), 64'd1);
        push(2, 1'b1, memFn(32'h70), cyc + 3);
        tick();
        dReq[2] = 1'b0;

        for (int w = 0; w < 20 && sbq.size() != 0; w++) tick();
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
